gcd_engine: RTL and testbench

//  Parametrised iterative GCD unit: successor to the 8-bit subtractive GCD block.

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_step.sv | 57 +++++
 rtl/gcd_engine.sv | 128 ++++++++++++
 tb/tb_gcd_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
//   gcd_state_t : controller states (idle / iterating)
//   MODE_SUB    : subtractive Euclid algorithm select
//   MODE_BIN    : binary (Stein) algorithm select
package gcd_pkg;

  typedef enum logic {S_IDLE, S_CALC} gcd_state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration for either algorithm.
//   a, b      : current operands
//   md        : algorithm select (MODE_SUB / MODE_BIN)
//   a_nxt     : operand A after one step
//   b_nxt     : operand B after one step
//   k_inc     : Stein step removed a common factor of two
//   eq        : a == b (termination condition)
//   any_zero  : a or b is zero (degenerate input)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             k_inc,
  output logic             eq,
  output logic             any_zero
);

  assign eq       = (a == b);
  assign any_zero = (a == '0) || (b == '0);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_inc = 1'b0;
    if (md == MODE_SUB) begin
      // Keep a >= b so the subtraction never underflows.
      if (a < b) begin
        a_nxt = b;
        b_nxt = a;
      end else begin
        a_nxt = a - b;
      end
    end else begin
      case ({a[0], b[0]})
        2'b00: begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_inc = 1'b1;
        end
        2'b01: a_nxt = a >> 1;
        2'b10: b_nxt = b >> 1;
        default: begin
          // Difference of two odd numbers is even, so halve it right away.
          if (a >= b) a_nxt = (a - b) >> 1;
          else        b_nxt = (b - a) >> 1;
        end
      endcase
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD unit with start/ready handshake and selectable algorithm.
//   clk, nrst : clock (posedge), asynchronous active-low reset
//   start     : request, taken on an edge where ready=1
//   mode      : 0 subtractive Euclid, 1 binary Stein (sampled with start)
//   ina, inb  : operands (sampled with start)
//   ready     : idle, a start will be accepted
//   valid     : one-cycle pulse when out/cycles/zero_in were just updated
//   out       : last result, held between operations
//   cycles    : iteration count of last operation, saturating
//   zero_in   : last operation had a zero operand
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] cycles,
  output logic             zero_in
);

  // Holds the count of common factors of two stripped by Stein.
  localparam int KW = $clog2(WIDTH) + 1;

  gcd_state_t       state, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, b_nxt;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] cnt;
  logic             md;
  logic             k_inc, eq, any_zero;
  logic             accept, step, fin, fin_zero;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .b        (b),
    .md       (md),
    .a_nxt    (a_nxt),
    .b_nxt    (b_nxt),
    .k_inc    (k_inc),
    .eq       (eq),
    .any_zero (any_zero)
  );

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    fin_zero  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // Zero test only matters before any step: steps never create a zero.
        if ((cnt == '0) && any_zero) begin
          fin_zero  = 1'b1;
          state_nxt = S_IDLE;
        end else if (eq) begin
          fin       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a       <= '0;
      b       <= '0;
      k       <= '0;
      md      <= MODE_SUB;
      cnt     <= '0;
      valid   <= 1'b0;
      out     <= '0;
      cycles  <= '0;
      zero_in <= 1'b0;
    end else begin
      valid <= fin | fin_zero;
      if (accept) begin
        a   <= ina;
        b   <= inb;
        md  <= mode;
        k   <= '0;
        cnt <= '0;
      end
      if (step) begin
        a   <= a_nxt;
        b   <= b_nxt;
        k   <= k + {{(KW-1){1'b0}}, k_inc};
        cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
      end
      if (fin_zero) begin
        out     <= a | b;
        zero_in <= 1'b1;
        cycles  <= '0;
      end
      if (fin) begin
        // Restore the common power of two; k stays 0 in subtractive mode.
        out     <= a << k;
        zero_in <= 1'b0;
        cycles  <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: WIDTH=8 and WIDTH=16 instances share clock/reset.
module tb_gcd_engine;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int out;
    int steps;
    int cyc_sat;
    bit z;
    int acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  logic        start8 = 0, mode8 = 0;
  logic [7:0]  ina8 = 0, inb8 = 0;
  logic        ready8, valid8, zero8;
  logic [7:0]  out8, cycles8;

  logic        start16 = 0, mode16 = 0;
  logic [15:0] ina16 = 0, inb16 = 0;
  logic        ready16, valid16, zero16;
  logic [15:0] out16;
  logic [7:0]  cycles16;

  gcd_engine #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .nrst(nrst), .start(start8), .mode(mode8), .ina(ina8), .inb(inb8),
    .ready(ready8), .valid(valid8), .out(out8), .cycles(cycles8), .zero_in(zero8)
  );

  gcd_engine #(.WIDTH(16), .CNT_W(8)) dut16 (
    .clk(clk), .nrst(nrst), .start(start16), .mode(mode16), .ina(ina16), .inb(inb16),
    .ready(ready16), .valid(valid16), .out(out16), .cycles(cycles16), .zero_in(zero16)
  );

  // ---------------- reference model ----------------
  function automatic int gcd_ref(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Iteration count: Euclid via quotients (q subtracts then a swap per stage),
  // Stein by walking its halving/subtract rules.
  function automatic int steps_ref(int a, int b, bit m);
    int n = 0;
    int t;
    if (a == 0 || b == 0) return 0;
    if (!m) begin
      if (a < b) begin t = a; a = b; b = t; n++; end
      forever begin
        if (a % b == 0) return n + a / b - 1;
        n += a / b + 1;
        t = a % b;
        a = b;
        b = t;
      end
    end else begin
      while (a != b) begin
        if (a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
        else if (a % 2 == 0) a /= 2;
        else if (b % 2 == 0) b /= 2;
        else if (a >= b) a = (a - b) / 2;
        else b = (b - a) / 2;
        n++;
      end
      return n;
    end
    return n;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (valid8 === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("out8", out8, e.out);
        chk("cycles8", cycles8, e.cyc_sat);
        chk("zero_in8", zero8, e.z);
        chk("latency8", cyc, e.acc + e.steps + 1);
      end
    end
    if (valid16 === 1'b1) begin
      if (q16.size() == 0) chk("unexpected_valid16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("out16", out16, e.out);
        chk("cycles16", cycles16, e.cyc_sat);
        chk("zero_in16", zero16, e.z);
        chk("latency16", cyc, e.acc + e.steps + 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Raises start at a negedge and holds it until the DUT is ready, so a request
  // made during CALC exercises the back-to-back path.
  task automatic issue(bit sel, bit m, int a, int b);
    exp_t e;
    int t = 0;
    @(negedge clk);
    if (sel) begin start16 = 1; mode16 = m; ina16 = a[15:0]; inb16 = b[15:0]; end
    else     begin start8  = 1; mode8  = m; ina8  = a[7:0];  inb8  = b[7:0];  end
    while (!(sel ? ready16 : ready8)) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        chk("ready_timeout", 0, 1);
        start8 = 0; start16 = 0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.out = gcd_ref(a, b);
    e.steps = steps_ref(a, b, m);
    e.cyc_sat = (e.steps > 255) ? 255 : e.steps;
    e.z = (a == 0 || b == 0);
    e.acc = cyc;
    if (sel) begin q16.push_back(e); start16 = 0; end
    else     begin q8.push_back(e);  start8 = 0;  end
  endtask

  task automatic drain();
    int t = 0;
    while (q8.size() != 0 || q16.size() != 0 || !ready8 || !ready16) begin
      @(negedge clk);
      t++;
      if (t > 20000) begin
        chk("drain_timeout", 0, 1);
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int a, b;
    bit m;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", ready8, 1);
    chk("rst_valid", valid8, 0);
    chk("rst_out", out8, 0);
    chk("rst_cycles", cycles8, 0);
    chk("rst_zero_in", zero8, 0);
    @(negedge clk);
    nrst = 1;

    // directed cases
    issue(0, 0, 12, 8);
    issue(0, 1, 12, 8);
    issue(0, 0, 0, 9);
    issue(0, 1, 0, 9);
    issue(0, 0, 9, 0);
    issue(0, 1, 0, 0);
    issue(0, 0, 77, 77);
    issue(0, 0, 255, 1);
    issue(0, 1, 255, 1);
    issue(0, 1, 128, 192);
    drain();

    // start pulsed with new operands during CALC must be ignored
    issue(0, 0, 100, 7);
    @(negedge clk);
    chk("busy_ready", ready8, 0);
    start8 = 1; mode8 = 1; ina8 = 8'd3; inb8 = 8'd9;
    @(negedge clk);
    start8 = 0;
    // next request held from inside CALC until ready rises
    issue(0, 1, 60, 48);
    issue(0, 0, 35, 21);
    drain();

    // asynchronous reset mid-operation
    issue(0, 0, 200, 3);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", ready8, 0);
    nrst = 0;
    #1;
    q8.delete();
    chk("midrst_ready", ready8, 1);
    chk("midrst_valid", valid8, 0);
    chk("midrst_out", out8, 0);
    chk("midrst_cycles", cycles8, 0);
    chk("midrst_zero_in", zero8, 0);
    @(negedge clk);
    nrst = 1;
    issue(0, 1, 48, 36);
    issue(0, 0, 48, 36);
    drain();

    // random, WIDTH=8
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 1);
      a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      issue(0, m, a, b);
    end
    drain();

    // random, WIDTH=16 (long subtractive runs skipped to bound run time)
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 1);
      do begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(1, 65535);
      end while (steps_ref(a, b, m) > 3000);
      issue(1, m, a, b);
    end
    issue(1, 0, 0, 4321);
    issue(1, 1, 40000, 40000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
